// File: rtl/bus_key_sequencer.sv
// bus_key_sequencer: snoops qualified bus reads, steps an LFSR per access
// and unlocks once a programmable address-field key sequence is seen.
module bus_key_sequencer #(
    parameter int                         ADDR_W   = 14,
    parameter logic [1:0]                 WIN      = 2'b01,
    parameter int                         NIB_LSB  = 4,
    parameter int                         NIB_W    = 4,
    parameter int                         DEPTH    = 4,
    parameter int                         STATE_W  = 6,
    parameter logic [STATE_W-1:0]         SEED     = 6'h01,
    parameter logic [STATE_W-1:0]         TAPS     = 6'h30,
    parameter logic [STATE_W-1:0]         OUT_MASK = 6'h2D,
    parameter logic [DEPTH*NIB_W-1:0]     INIT     = 16'h5A3C,
    localparam int                        IDX_W    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  bus_addr,
    input  logic               bus_rd,
    input  logic               sser_n,
    input  logic               bus_stb,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [NIB_W-1:0]   cfg_nib,
    output logic               rd_oe,
    output logic               rd_data,
    output logic               unlocked,
    output logic [IDX_W-1:0]   seq_idx,
    output logic [STATE_W-1:0] state
);

    typedef enum logic {
        S_LOCKED   = 1'b0,
        S_UNLOCKED = 1'b1
    } lock_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

    lock_t              lock_q, lock_d;
    logic [IDX_W-1:0]   idx_d;
    logic [NIB_W-1:0]   key_tab [DEPTH];
    logic               sel, acc, cfg_ok;
    logic [NIB_W-1:0]   fld;
    logic [STATE_W-1:0] lfsr_fb, lfsr_nxt;
    logic               unused_addr;

    assign sel = ~sser_n & bus_rd & (bus_addr[ADDR_W-1 -: 2] == WIN);
    assign acc = sel & bus_stb;
    assign fld = bus_addr[NIB_LSB +: NIB_W];
    assign unused_addr = ^bus_addr;

    // A table index beyond DEPTH-1 is only reachable for non power-of-two depths.
    generate
        if ((2 ** IDX_W) == DEPTH) begin : g_full_idx
            assign cfg_ok = 1'b1;
        end else begin : g_part_idx
            assign cfg_ok = (32'(cfg_idx) < DEPTH);
        end
    endgenerate

    // LFSR step, falling back to the seed instead of locking up at zero.
    always_comb begin
        lfsr_fb  = {state[STATE_W-2:0], ^(state & TAPS)};
        lfsr_nxt = (lfsr_fb == '0) ? SEED : lfsr_fb;
    end

    // LFSR register advances once per qualified access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else if (acc) begin
            state <= lfsr_nxt;
        end
    end

    // Key table: reloaded from INIT on reset, writable through the cfg port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                key_tab[i] <= INIT[i*NIB_W +: NIB_W];
            end
        end else if (cfg_we && cfg_ok) begin
            key_tab[cfg_idx] <= cfg_nib;
        end
    end

    // Lock state and sequence position registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q  <= S_LOCKED;
            seq_idx <= '0;
        end else begin
            lock_q  <= lock_d;
            seq_idx <= idx_d;
        end
    end

    // Sequence matcher; a valid config write overrides matching that cycle.
    always_comb begin
        lock_d = lock_q;
        idx_d  = seq_idx;
        if (cfg_we && cfg_ok) begin
            lock_d = S_LOCKED;
            idx_d  = '0;
        end else if (acc) begin
            unique case (lock_q)
                S_LOCKED: begin
                    if (fld == key_tab[seq_idx]) begin
                        if (seq_idx == LAST) begin
                            lock_d = S_UNLOCKED;
                            idx_d  = '0;
                        end else begin
                            idx_d = seq_idx + IDX_W'(1);
                        end
                    end else if (fld == key_tab[0]) begin
                        idx_d = IDX_W'(1);
                    end else begin
                        idx_d = '0;
                    end
                end
                S_UNLOCKED: begin
                    idx_d = '0;
                    if (fld == '1) begin
                        lock_d = S_LOCKED;
                    end
                end
                default: begin
                    lock_d = S_LOCKED;
                    idx_d  = '0;
                end
            endcase
        end
    end

    // Readout reflects the pre-update state during the strobe cycle.
    always_comb begin
        unlocked = (lock_q == S_UNLOCKED);
        rd_oe    = sel;
        rd_data  = sel & (unlocked ? ^(state & OUT_MASK) : 1'b1);
    end

endmodule

// File: tb/tb_bus_key_sequencer.sv
// tb_bus_key_sequencer: directed checks of reset, LFSR, unlock, mismatch,
// qualification, relock and key table configuration.
module tb_bus_key_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] bus_addr;
    logic        bus_rd;
    logic        sser_n;
    logic        bus_stb;
    logic        cfg_we;
    logic [1:0]  cfg_idx;
    logic [3:0]  cfg_nib;
    logic        rd_oe;
    logic        rd_data;
    logic        unlocked;
    logic [1:0]  seq_idx;
    logic [5:0]  state;

    int n_cmp = 0;
    int n_err = 0;

    logic       s_oe, s_dat;
    logic [5:0] exp_st;
    logic       seen_zero;

    bus_key_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus_addr (bus_addr),
        .bus_rd   (bus_rd),
        .sser_n   (sser_n),
        .bus_stb  (bus_stb),
        .cfg_we   (cfg_we),
        .cfg_idx  (cfg_idx),
        .cfg_nib  (cfg_nib),
        .rd_oe    (rd_oe),
        .rd_data  (rd_data),
        .unlocked (unlocked),
        .seq_idx  (seq_idx),
        .state    (state)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] lfsr(input logic [5:0] s);
        logic [5:0] n;
        n = {s[4:0], s[5] ^ s[4]};
        return (n == 6'h00) ? 6'h01 : n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle with the given bus drive; readout sampled before the edge.
    task automatic cyc(input logic [13:0] a, input logic rd,
                       input logic ssn, input logic stb);
        @(negedge clk);
        bus_addr = a;
        bus_rd   = rd;
        sser_n   = ssn;
        bus_stb  = stb;
        #1;
        s_oe  = rd_oe;
        s_dat = rd_data;
        @(posedge clk);
        #1;
        bus_stb = 1'b0;
        cfg_we  = 1'b0;
    endtask

    task automatic rd(input logic [13:0] a);
        cyc(a, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        bus_rd  = 1'b0;
        sser_n  = 1'b1;
        bus_stb = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus_addr = '0;
        cfg_we   = 1'b0;
        cfg_idx  = '0;
        cfg_nib  = '0;
        do_reset();
        #1;
        chk("rst_state", 32'(state), 32'h01);
        chk("rst_idx", 32'(seq_idx), 0);
        chk("rst_unl", 32'(unlocked), 0);
        chk("rst_oe", 32'(rd_oe), 0);
        chk("rst_data", 32'(rd_data), 0);

        rd(14'h1000);
        chk("lock_oe", 32'(s_oe), 1);
        chk("lock_data", 32'(s_dat), 1);
        chk("lfsr1", 32'(state), 32'h02);
        rd(14'h1000); chk("lfsr2", 32'(state), 32'h04);
        rd(14'h1000); chk("lfsr3", 32'(state), 32'h08);
        rd(14'h1000); chk("lfsr4", 32'(state), 32'h10);
        rd(14'h1000); chk("lfsr5", 32'(state), 32'h21);
        rd(14'h1000); chk("lfsr6", 32'(state), 32'h03);
        seen_zero = 1'b0;
        for (int i = 6; i < 63; i++) begin
            rd(14'h1000);
            if (state == 6'h00) seen_zero = 1'b1;
        end
        chk("lfsr_nz", 32'(seen_zero), 0);
        chk("lfsr63", 32'(state), 32'h01);

        cyc(14'h10C0, 1'b1, 1'b0, 1'b0);
        chk("nostb_oe", 32'(s_oe), 1);
        chk("nostb_st", 32'(state), 32'h01);
        chk("nostb_idx", 32'(seq_idx), 0);

        do_reset();
        rd(14'h10C0); chk("ul_i1", 32'(seq_idx), 1);
        chk("ul_d1", 32'(s_dat), 1);
        rd(14'h1030); chk("ul_i2", 32'(seq_idx), 2);
        rd(14'h10A0); chk("ul_i3", 32'(seq_idx), 3);
        chk("ul_pre", 32'(unlocked), 0);
        chk("ul_d3", 32'(s_dat), 1);
        rd(14'h1050); chk("ul_i0", 32'(seq_idx), 0);
        chk("ul_unl", 32'(unlocked), 1);
        chk("ul_st", 32'(state), 32'h10);
        rd(14'h1000); chk("ul_r1", 32'(s_dat), 0);
        rd(14'h1000); chk("ul_r2", 32'(s_dat), 0);
        rd(14'h1000); chk("ul_r3", 32'(s_dat), 1);
        chk("ul_hold", 32'(unlocked), 1);

        do_reset();
        rd(14'h10C0); chk("mm1", 32'(seq_idx), 1);
        rd(14'h1030); chk("mm2", 32'(seq_idx), 2);
        rd(14'h10C0); chk("mm3", 32'(seq_idx), 1);
        rd(14'h1030); chk("mm4", 32'(seq_idx), 2);
        rd(14'h10A0); chk("mm5", 32'(seq_idx), 3);
        chk("mm5_unl", 32'(unlocked), 0);
        rd(14'h1050); chk("mm6_unl", 32'(unlocked), 1);
        rd(14'h10F0); chk("relock", 32'(unlocked), 0);
        rd(14'h10C0); chk("mm_c", 32'(seq_idx), 1);
        rd(14'h1070); chk("mm_7", 32'(seq_idx), 0);

        do_reset();
        for (int v = 0; v < 3; v++) begin
            logic [13:0] keys [4];
            keys[0] = 14'h10C0; keys[1] = 14'h1030;
            keys[2] = 14'h10A0; keys[3] = 14'h1050;
            for (int k = 0; k < 4; k++) begin
                if (v == 0) cyc(keys[k], 1'b1, 1'b1, 1'b1);
                else if (v == 1) cyc(keys[k], 1'b0, 1'b0, 1'b1);
                else cyc(keys[k] | 14'h3000, 1'b1, 1'b0, 1'b1);
                chk($sformatf("q%0d_oe", v), 32'(s_oe), 0);
                chk($sformatf("q%0d_dat", v), 32'(s_dat), 0);
            end
            chk($sformatf("q%0d_st", v), 32'(state), 32'h01);
            chk($sformatf("q%0d_idx", v), 32'(seq_idx), 0);
            chk($sformatf("q%0d_unl", v), 32'(unlocked), 0);
        end

        rd(14'h10C0);
        rd(14'h1030);
        chk("ab_pre", 32'(seq_idx), 2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("ab_idx", 32'(seq_idx), 0);
        chk("ab_st", 32'(state), 32'h01);
        @(negedge clk);
        rst_n = 1'b1;

        exp_st = 6'h01;
        rd(14'h10C0); rd(14'h1030); rd(14'h10A0); rd(14'h1050);
        for (int i = 0; i < 4; i++) exp_st = lfsr(exp_st);
        chk("cf_unl0", 32'(unlocked), 1);
        rd(14'h10F0);
        exp_st = lfsr(exp_st);
        chk("cf_relock", 32'(unlocked), 0);
        cfg_we  = 1'b1;
        cfg_idx = 2'd0;
        cfg_nib = 4'h9;
        rd(14'h10C0);
        exp_st = lfsr(exp_st);
        chk("cf_idx", 32'(seq_idx), 0);
        chk("cf_unl", 32'(unlocked), 0);
        chk("cf_st", 32'(state), 32'(exp_st));
        rd(14'h10C0); chk("cf_oldc", 32'(seq_idx), 0);
        rd(14'h1090); chk("cf_9", 32'(seq_idx), 1);
        rd(14'h1030); rd(14'h10A0); rd(14'h1050);
        chk("cf_new_unl", 32'(unlocked), 1);

        do_reset();
        rd(14'h10C0); rd(14'h1030); rd(14'h10A0); rd(14'h1050);
        chk("init_reload", 32'(unlocked), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
